assert_window_checker: RTL and testbench
========================================

# assert_window_checker

Synthesizable multi-channel temporal checker implementing, per channel, the property "antecedent |-> ##[MIN_DLY:MAX_DLY] consequent" with a disable condition. It generalises our fixed-delay concurrent assertions into hardware that can be instantiated next to the DUT in both simulation and emulation builds. Results go to self-checking benches and status registers as pass/fail pulses, sticky flags, saturating error counters and first-failure capture.

## Interface
- NCH, 4, number of independent channels (1..32)
- MIN_DLY, 2, earliest consequent sample after antecedent, in cycles (>=1)
- MAX_DLY, 2, latest consequent sample after antecedent (MIN_DLY..16)
- CNT_W, 8, width of each per-channel error counter
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high; clears all state
- en  in  1  global enable; when 0, no new attempts start (pending attempts keep running)
- dis  in  NCH  per-channel disable (disable iff); flushes that channel
- ant  in  NCH  per-channel antecedent
- cons  in  NCH  per-channel consequent
- clr  in  1  synchronous clear of sticky flags, counters, first-fail capture
- pass_o  out  NCH  one-cycle pulse: at least one pending attempt satisfied
- fail_o  out  NCH  one-cycle pulse: an attempt expired unsatisfied
- fail_sticky_o  out  NCH  set by fail, held until clr
- err_cnt_o  out  NCH*CNT_W  per-channel saturating fail count, channel c at bits [c*CNT_W +: CNT_W]
- first_fail_vld_o  out  1  a failure has been captured since reset/clr
- first_fail_ch_o  out  $clog2(NCH) (min 1)  channel of first failure

## Operation
- Edge numbering: antecedent sampled high at edge E0 (en=1, dis[c]=0) starts an attempt of age 0.
- Per channel, a MAX_DLY-deep pending vector; bit k = live attempt of age k; shifts every edge.
- At edge Ek, an attempt with MIN_DLY<=k<=MAX_DLY and cons[c]=1 is satisfied and removed; one cons sample satisfies all eligible attempts simultaneously (overlapping attempts allowed, one new per cycle).
- Attempt at age MAX_DLY with cons[c]=0 expires: fail. At most one expiry per channel per cycle.
- cons outside window (k<MIN_DLY) is ignored for that attempt.
- dis[c]=1 at an edge: all pending attempts of c cleared, no pass/fail that edge, no new attempt even if ant[c]=1.
- err_cnt increments by 1 per fail, saturates at 2^CNT_W-1, never wraps.
- First-fail capture: on first fail after reset/clr, record lowest failing index; later fails ignored until clr.
- clr and fail on the same edge: fail wins (sticky=1, count=1, capture loaded with that channel).
- Illegal parameters (MIN_DLY<1, MAX_DLY<MIN_DLY, MAX_DLY>16, NCH outside 1..32) are elaboration errors.

## Timing
- All outputs registered; reset value 0 for every output.
- pass_o[c]/fail_o[c] high in the cycle after edge Ek at which the deciding sample is taken; width exactly one cycle unless re-triggered.
- Fixed window (MIN=MAX=2): ant at E0, cons low at E2 -> fail_o high after E2.
- fail_sticky_o, err_cnt_o, first_fail_* update on the same edge as fail_o.
- rst asserted mid-operation: pending attempts dropped immediately, outputs to 0 asynchronously; first attempt after release needs a fresh antecedent.
- No throughput limit: new attempt every cycle per channel.

## Structure
- Package assert_chk_pkg: MAX_DLY_LIMIT=16, NCH_LIMIT=32, parameter-check function, err-count saturating increment function.
- Sub-module assert_window_lane: one channel (pending vector, pass/fail, sticky, counter), generated NCH times; top holds enable gating, clr distribution and first-fail priority encoder.

## Test plan
- MIN=MAX=2, ch0: ant=1 at E0, cons=1 at E2 -> pass_o[0] pulse after E2, no fail, err_cnt=0.
- MIN=MAX=2, ch0: ant at E0, cons=0 at E2 -> fail_o[0] one pulse, sticky=1, err_cnt=1, first_fail_ch=0.
- MIN=1,MAX=3: ant at E0,E1,E2; cons only at E3 -> single pass_o pulse after E3 satisfying all three, no fail.
- ch2 and ch1 fail same edge -> first_fail_ch=1; then clr with ch3 fail same edge -> first_fail_ch=3, ch3 count=1, ch1/ch2 counts=0.
- CNT_W=2: five consecutive expiries -> err_cnt stays 3.
- ant at E0, dis at E1 -> no pass/fail at E2; assert rst at E1 on another channel -> all outputs 0 immediately.

Source files
------------

// File: rtl/assert_chk_pkg.sv
// Shared limits and helpers for the windowed assertion checker.
package assert_chk_pkg;

    localparam int MAX_DLY_LIMIT = 16;
    localparam int NCH_LIMIT     = 32;

    // True when the channel count and delay window form a legal configuration.
    function automatic bit params_legal(input int nch, input int min_dly, input int max_dly);
        return (nch >= 1) && (nch <= NCH_LIMIT) &&
               (min_dly >= 1) && (max_dly >= min_dly) && (max_dly <= MAX_DLY_LIMIT);
    endfunction

    // Increment a counter of the given width, sticking at its all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : (value + 32'd1);
    endfunction

endpackage

// File: rtl/assert_window_lane.sv
// One checker channel: pending-attempt shift vector, pass/fail pulses,
// sticky failure flag and saturating error counter.
module assert_window_lane
    import assert_chk_pkg::*;
#(
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             dis_i,
    input  logic             cons_i,
    input  logic             clr_i,
    output logic             fail_next_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             fail_sticky_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    // Bit k of the pending vector holds an attempt that reaches age k+1 at the
    // next edge; the mask marks the ages inside the consequent window.
    localparam logic [MAX_DLY-1:0] WIN_MASK =
        ~MAX_DLY'((32'd1 << (MIN_DLY - 1)) - 32'd1);

    logic [MAX_DLY-1:0] pend_q, pend_d;
    logic [MAX_DLY-1:0] survivors;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Age attempts, retire satisfied or expired ones and update the status.
    always_comb begin
        pend_d    = '0;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
        survivors = pend_q;
        if (!dis_i) begin
            pass_d    = cons_i && (|(pend_q & WIN_MASK));
            fail_d    = pend_q[MAX_DLY-1] && !cons_i;
            survivors = cons_i ? (pend_q & ~WIN_MASK) : pend_q;
            pend_d    = (survivors << 1) | MAX_DLY'(start_i);
        end
        if (clr_i) begin
            sticky_d = fail_d;
            cnt_d    = fail_d ? CNT_W'(1) : '0;
        end else begin
            sticky_d = sticky_q | fail_d;
            cnt_d    = fail_d ? CNT_W'(sat_inc(32'(cnt_q), CNT_W)) : cnt_q;
        end
    end

    // Lane state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pend_q   <= pend_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign fail_next_o   = fail_d;
    assign pass_o        = pass_q;
    assign fail_o        = fail_q;
    assign fail_sticky_o = sticky_q;
    assign err_cnt_o     = cnt_q;

endmodule

// File: rtl/assert_window_checker.sv
// Multi-channel "ant |-> ##[MIN_DLY:MAX_DLY] cons" checker with disable,
// sticky flags, saturating error counters and first-failure capture.
module assert_window_checker
    import assert_chk_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 2,
    parameter int CNT_W   = 8,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH-1:0]       dis,
    input  logic [NCH-1:0]       ant,
    input  logic [NCH-1:0]       cons,
    input  logic                 clr,
    output logic [NCH-1:0]       pass_o,
    output logic [NCH-1:0]       fail_o,
    output logic [NCH-1:0]       fail_sticky_o,
    output logic [NCH*CNT_W-1:0] err_cnt_o,
    output logic                 first_fail_vld_o,
    output logic [CH_W-1:0]      first_fail_ch_o
);

    if (!params_legal(NCH, MIN_DLY, MAX_DLY)) begin : g_bad_params
        $fatal(1, "assert_window_checker: illegal NCH/MIN_DLY/MAX_DLY combination");
    end

    logic [NCH-1:0]  start;
    logic [NCH-1:0]  fail_next;
    logic            any_fail;
    logic [CH_W-1:0] low_ch;
    logic            ff_vld_q, ff_vld_d;
    logic [CH_W-1:0] ff_ch_q, ff_ch_d;

    // The global enable only gates new attempts; pending ones keep aging.
    assign start = ant & {NCH{en}};

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        assert_window_lane #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY),
            .CNT_W   (CNT_W)
        ) u_lane (
            .clk           (clk),
            .rst           (rst),
            .start_i       (start[c]),
            .dis_i         (dis[c]),
            .cons_i        (cons[c]),
            .clr_i         (clr),
            .fail_next_o   (fail_next[c]),
            .pass_o        (pass_o[c]),
            .fail_o        (fail_o[c]),
            .fail_sticky_o (fail_sticky_o[c]),
            .err_cnt_o     (err_cnt_o[c*CNT_W +: CNT_W])
        );
    end

    // Lowest failing channel this edge; a fail coinciding with clr is captured.
    always_comb begin
        any_fail = |fail_next;
        low_ch   = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (fail_next[c]) begin
                low_ch = CH_W'(c);
            end
        end
        ff_vld_d = clr ? 1'b0 : ff_vld_q;
        ff_ch_d  = clr ? '0 : ff_ch_q;
        if (any_fail && !ff_vld_d) begin
            ff_vld_d = 1'b1;
            ff_ch_d  = low_ch;
        end
    end

    // First-failure capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_vld_q <= 1'b0;
            ff_ch_q  <= '0;
        end else begin
            ff_vld_q <= ff_vld_d;
            ff_ch_q  <= ff_ch_d;
        end
    end

    assign first_fail_vld_o = ff_vld_q;
    assign first_fail_ch_o  = ff_ch_q;

endmodule

// File: tb/tb_assert_window_checker.sv
// Bench for assert_window_checker: two configurations driven in parallel,
// compared every cycle against a timestamp-based model of the property.
module tb_assert_window_checker;

    localparam int NCH = 4;
    localparam int MN   [2] = '{2, 1};
    localparam int MX   [2] = '{2, 3};
    localparam int CW   [2] = '{8, 2};
    localparam int CMAX [2] = '{255, 3};

    logic           clk;
    logic           rst;
    logic           en;
    logic [NCH-1:0] dis, ant, cons;
    logic           clr;

    logic [NCH-1:0] a_pass, a_fail, a_sticky;
    logic [31:0]    a_cnt;
    logic           a_vld;
    logic [1:0]     a_ch;
    logic [NCH-1:0] b_pass, b_fail, b_sticky;
    logic [7:0]     b_cnt;
    logic           b_vld;
    logic [1:0]     b_ch;

    int checks   = 0;
    int failures = 0;
    logic check_en = 1'b0;

    // Model state: start edge of every live attempt, per configuration and channel.
    int             q [2][NCH][$];
    int             t;
    logic [NCH-1:0] e_pass [2];
    logic [NCH-1:0] e_fail [2];
    logic [NCH-1:0] e_sticky [2];
    int             e_cnt [2][NCH];
    logic           e_vld [2];
    int             e_ch [2];

    assert_window_checker #(.NCH(NCH), .MIN_DLY(2), .MAX_DLY(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .dis(dis), .ant(ant), .cons(cons), .clr(clr),
        .pass_o(a_pass), .fail_o(a_fail), .fail_sticky_o(a_sticky), .err_cnt_o(a_cnt),
        .first_fail_vld_o(a_vld), .first_fail_ch_o(a_ch)
    );

    assert_window_checker #(.NCH(NCH), .MIN_DLY(1), .MAX_DLY(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .dis(dis), .ant(ant), .cons(cons), .clr(clr),
        .pass_o(b_pass), .fail_o(b_fail), .fail_sticky_o(b_sticky), .err_cnt_o(b_cnt),
        .first_fail_vld_o(b_vld), .first_fail_ch_o(b_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic modelClear();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                q[d][c].delete();
                e_cnt[d][c] = 0;
            end
            e_pass[d]   = '0;
            e_fail[d]   = '0;
            e_sticky[d] = '0;
            e_vld[d]    = 1'b0;
            e_ch[d]     = 0;
        end
    endtask

    // One edge of the property: ages are measured as edge index minus start edge.
    task automatic modelStep();
        int nq[$];
        int age;
        logic elig, p, f;
        logic [NCH-1:0] fv;
        t++;
        for (int d = 0; d < 2; d++) begin
            fv = '0;
            for (int c = 0; c < NCH; c++) begin
                p = 1'b0;
                f = 1'b0;
                if (dis[c]) begin
                    q[d][c].delete();
                end else begin
                    elig = 1'b0;
                    nq.delete();
                    for (int i = 0; i < q[d][c].size(); i++) begin
                        age = t - q[d][c][i];
                        if (age >= MN[d] && age <= MX[d]) elig = 1'b1;
                        if (cons[c] && age >= MN[d]) begin
                            // satisfied and retired
                        end else if (!cons[c] && age == MX[d]) begin
                            f = 1'b1;
                        end else begin
                            nq.push_back(q[d][c][i]);
                        end
                    end
                    p = cons[c] && elig;
                    q[d][c].delete();
                    for (int i = 0; i < nq.size(); i++) q[d][c].push_back(nq[i]);
                    if (en && ant[c]) q[d][c].push_back(t);
                end
                e_pass[d][c] = p;
                e_fail[d][c] = f;
                fv[c] = f;
                if (clr) begin
                    e_sticky[d][c] = f;
                    e_cnt[d][c]    = f ? 1 : 0;
                end else if (f) begin
                    e_sticky[d][c] = 1'b1;
                    e_cnt[d][c]    = (e_cnt[d][c] < CMAX[d]) ? e_cnt[d][c] + 1 : CMAX[d];
                end
            end
            if (clr) begin
                e_vld[d] = 1'b0;
                e_ch[d]  = 0;
            end
            if (fv != '0 && !e_vld[d]) begin
                e_vld[d] = 1'b1;
                for (int c = NCH - 1; c >= 0; c--) if (fv[c]) e_ch[d] = c;
            end
        end
    endtask

    function automatic logic [31:0] packCnt(input int d);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v = v | (32'(e_cnt[d][c]) << (c * CW[d]));
        return v;
    endfunction

    task automatic checkOutput();
        chk("A.pass",   32'(a_pass),   32'(e_pass[0]));
        chk("A.fail",   32'(a_fail),   32'(e_fail[0]));
        chk("A.sticky", 32'(a_sticky), 32'(e_sticky[0]));
        chk("A.cnt",    a_cnt,         packCnt(0));
        chk("A.ffvld",  32'(a_vld),    32'(e_vld[0]));
        chk("A.ffch",   32'(a_ch),     32'(e_ch[0]));
        chk("B.pass",   32'(b_pass),   32'(e_pass[1]));
        chk("B.fail",   32'(b_fail),   32'(e_fail[1]));
        chk("B.sticky", 32'(b_sticky), 32'(e_sticky[1]));
        chk("B.cnt",    32'(b_cnt),    packCnt(1));
        chk("B.ffvld",  32'(b_vld),    32'(e_vld[1]));
        chk("B.ffch",   32'(b_ch),     32'(e_ch[1]));
    endtask

    // Model advances on every active edge using the inputs the DUTs sampled.
    always @(posedge clk) begin
        if (rst) modelClear();
        else     modelStep();
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    task automatic applyStimulus(input logic e, input logic [NCH-1:0] d, input logic [NCH-1:0] a,
                                 input logic [NCH-1:0] cs, input logic cl);
        @(negedge clk);
        en   = e;
        dis  = d;
        ant  = a;
        cons = cs;
        clr  = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (4) applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
    endtask

    initial begin
        logic [NCH-1:0] rd;
        t    = 0;
        rst  = 1'b1;
        en   = 1'b0;
        dis  = '0;
        ant  = '0;
        cons = '0;
        clr  = 1'b0;
        modelClear();
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.A.sticky", 32'(a_sticky), 32'h0);
        chk("reset.A.cnt", a_cnt, 32'h0);
        chk("reset.B.ffvld", 32'(b_vld), 32'h0);
        rst = 1'b0;

        // Fixed window, consequent on time.
        drain();
        applyStimulus(1'b1, 4'h0, 4'h1, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h1, 1'b0);
        chk("t1.A.pass0", 32'(a_pass[0]), 32'h1);
        chk("t1.A.fail0", 32'(a_fail[0]), 32'h0);
        chk("t1.A.cnt0", 32'(a_cnt[7:0]), 32'h0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("t1.A.pass0.width", 32'(a_pass[0]), 32'h0);

        // Fixed window, consequent missing.
        drain();
        applyStimulus(1'b1, 4'h0, 4'h1, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("t2.A.fail", 32'(a_fail), 32'h1);
        chk("t2.A.sticky0", 32'(a_sticky[0]), 32'h1);
        chk("t2.A.cnt0", 32'(a_cnt[7:0]), 32'h1);
        chk("t2.A.ffvld", 32'(a_vld), 32'h1);
        chk("t2.A.ffch", 32'(a_ch), 32'h0);

        // Window 1..3: three overlapping attempts, one consequent.
        drain();
        repeat (3) applyStimulus(1'b1, 4'h0, 4'h1, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h1, 1'b0);
        chk("t3.B.pass0", 32'(b_pass[0]), 32'h1);
        chk("t3.B.fail0", 32'(b_fail[0]), 32'h0);
        repeat (3) begin
            applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
            chk("t3.B.nofail0", 32'(b_fail[0]), 32'h0);
        end
        chk("t3.B.sticky0", 32'(b_sticky[0]), 32'h0);

        // Simultaneous failures, then clr colliding with a new failure.
        drain();
        applyStimulus(1'b1, 4'h0, 4'h6, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("t4.A.fail", 32'(a_fail), 32'h6);
        chk("t4.A.ffch", 32'(a_ch), 32'h1);
        applyStimulus(1'b1, 4'h0, 4'h8, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("t4.A.ffvld", 32'(a_vld), 32'h1);
        chk("t4.A.ffch.clr", 32'(a_ch), 32'h3);
        chk("t4.A.cnt3", 32'(a_cnt[24 +: 8]), 32'h1);
        chk("t4.A.cnt1", 32'(a_cnt[8 +: 8]), 32'h0);
        chk("t4.A.cnt2", 32'(a_cnt[16 +: 8]), 32'h0);
        chk("t4.A.sticky", 32'(a_sticky), 32'h8);

        // Five expiries in a row: 8-bit counter reaches 5, 2-bit counter saturates.
        drain();
        repeat (5) applyStimulus(1'b1, 4'h0, 4'h1, 4'h0, 1'b0);
        repeat (5) applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("t5.A.cnt0", 32'(a_cnt[7:0]), 32'd5);
        chk("t5.B.cnt0.sat", 32'(b_cnt[1:0]), 32'd3);

        // Disable flushes a pending attempt.
        drain();
        applyStimulus(1'b1, 4'h0, 4'h1, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h1, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("t6.A.fail0.dis", 32'(a_fail[0]), 32'h0);
        chk("t6.A.pass0.dis", 32'(a_pass[0]), 32'h0);

        // Asynchronous reset in the middle of live attempts.
        drain();
        applyStimulus(1'b1, 4'h0, 4'h2, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("t7.A.sticky.pre", 32'(a_sticky), 32'h2);
        applyStimulus(1'b1, 4'h0, 4'h2, 4'h0, 1'b0);
        #2;
        rst = 1'b1;
        modelClear();
        #1;
        chk("t7.A.sticky.rst", 32'(a_sticky), 32'h0);
        chk("t7.A.cnt.rst", a_cnt, 32'h0);
        chk("t7.A.ffvld.rst", 32'(a_vld), 32'h0);
        chk("t7.B.sticky.rst", 32'(b_sticky), 32'h0);
        @(negedge clk);
        ant = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) applyStimulus(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
        chk("t7.A.fail.fresh", 32'(a_sticky), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < NCH; b++) rd[b] = ($urandom_range(0, 9) == 0);
            applyStimulus($urandom_range(0, 7) != 0, rd, NCH'($urandom), NCH'($urandom),
                          $urandom_range(0, 31) == 0);
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
